// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Holds the bus widths, the byte-lane count and the loader state encoding.
package imem_loader_pkg;

   localparam int unsigned IMEM_ADDR_W    = 32;
   localparam int unsigned INSTR_W        = 32;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned BYTE_CNT_W     = 2;

   // Loader states
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_LEN  = 3'd1;
   localparam state_t ST_DATA = 3'd2;
   localparam state_t ST_CSUM = 3'd3;
   localparam state_t ST_DONE = 3'd4;
   localparam state_t ST_ERR  = 3'd5;

endpackage : imem_loader_pkg

// File: rtl/byte_to_word_asm.sv
// Assembles little-endian 32-bit words from an accepted byte stream.
// Ports:
//   clk, reset     clock and synchronous active-low reset
//   clr            synchronous clear (new load); wins over byte_en
//   byte_en        a byte is accepted this cycle
//   byte_data      the accepted byte
//   word_o         assembled word, valid while word_done_o is high
//   word_done_o    combinational: this cycle's byte completes a word
module byte_to_word_asm
   import imem_loader_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               byte_en,
   input  logic [7:0]         byte_data,
   output logic [INSTR_W-1:0] word_o,
   output logic               word_done_o
);

   logic [BYTE_CNT_W-1:0] cnt;
   // Only lanes 0..2 are stored; lane 3 comes straight from the completing byte.
   logic [INSTR_W-9:0]    shreg;

   // Byte counter and lane storage
   always_ff @(posedge clk) begin
      if (!reset || clr) begin
         cnt   <= '0;
         shreg <= '0;
      end else if (byte_en) begin
         case (cnt)
            2'd0:    shreg[7:0]   <= byte_data;
            2'd1:    shreg[15:8]  <= byte_data;
            2'd2:    shreg[23:16] <= byte_data;
            default: ;
         endcase
         cnt <= cnt + 2'd1;
      end
   end

   // Word completion is flagged in the cycle of the 4th byte so the loader can register the write at that edge.
   assign word_done_o = byte_en && !clr && (cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
   assign word_o      = {byte_data, shreg};

endmodule : byte_to_word_asm

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream: length word, N data words, XOR checksum.
// Holds the CPU in reset until the image is loaded and the checksum matches.
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   start_i               begin a new load from any state
//   byte_data_i/valid_i   stream input; byte_ready_o is the handshake ready
//   wr_en_imem_o          one-cycle imem write strobe
//   addr_imem_o           imem byte address
//   wr_instr_imem_o       word to write
//   cpu_reset_o           active-low pipeline reset, high only after a good load
//   load_done_o           sticky: image loaded and checksum matched
//   load_err_o            sticky: length or checksum error
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter logic [IMEM_ADDR_W-1:0] BASE_ADDR = 32'h0,
   parameter int unsigned            MAX_WORDS = 256
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_i,
   input  logic [7:0]             byte_data_i,
   input  logic                   byte_valid_i,
   output logic                   byte_ready_o,
   output logic                   wr_en_imem_o,
   output logic [IMEM_ADDR_W-1:0] addr_imem_o,
   output logic [INSTR_W-1:0]     wr_instr_imem_o,
   output logic                   cpu_reset_o,
   output logic                   load_done_o,
   output logic                   load_err_o
);

   localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

   state_t                 state, state_d;
   logic                   ready_d, wr_en_d, cpu_reset_d, done_d, err_d;
   logic [IMEM_ADDR_W-1:0] addr_d;
   logic [INSTR_W-1:0]     instr_d;
   logic [INSTR_W-1:0]     csum, csum_d;
   logic [CNT_W-1:0]       word_cnt, word_cnt_d;
   logic [CNT_W-1:0]       len, len_d;

   logic                   byte_acc;
   logic [INSTR_W-1:0]     word;
   logic                   word_done;

   // A byte offered in the start cycle is dropped.
   assign byte_acc = byte_valid_i && byte_ready_o && !start_i;

   byte_to_word_asm u_asm (
      .clk         (clk),
      .reset       (reset),
      .clr         (start_i),
      .byte_en     (byte_acc),
      .byte_data   (byte_data_i),
      .word_o      (word),
      .word_done_o (word_done)
   );

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= ST_IDLE;
         byte_ready_o    <= 1'b0;
         wr_en_imem_o    <= 1'b0;
         addr_imem_o     <= BASE_ADDR;
         wr_instr_imem_o <= '0;
         cpu_reset_o     <= 1'b0;
         load_done_o     <= 1'b0;
         load_err_o      <= 1'b0;
         csum            <= '0;
         word_cnt        <= '0;
         len             <= '0;
      end else begin
         state           <= state_d;
         byte_ready_o    <= ready_d;
         wr_en_imem_o    <= wr_en_d;
         addr_imem_o     <= addr_d;
         wr_instr_imem_o <= instr_d;
         cpu_reset_o     <= cpu_reset_d;
         load_done_o     <= done_d;
         load_err_o      <= err_d;
         csum            <= csum_d;
         word_cnt        <= word_cnt_d;
         len             <= len_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      wr_en_d     = 1'b0;
      // The address advances in the cycle after each write.
      addr_d      = wr_en_imem_o ? (addr_imem_o + IMEM_ADDR_W'(BYTES_PER_WORD)) : addr_imem_o;
      instr_d     = wr_instr_imem_o;
      cpu_reset_d = cpu_reset_o;
      done_d      = load_done_o;
      err_d       = load_err_o;
      csum_d      = csum;
      word_cnt_d  = word_cnt;
      len_d       = len;

      if (start_i) begin
         state_d     = ST_LEN;
         addr_d      = BASE_ADDR;
         cpu_reset_d = 1'b0;
         done_d      = 1'b0;
         err_d       = 1'b0;
         csum_d      = '0;
         word_cnt_d  = '0;
         len_d       = '0;
      end else begin
         case (state)
            ST_LEN: begin
               if (word_done) begin
                  len_d = CNT_W'(word);
                  if (word > INSTR_W'(MAX_WORDS)) begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end else if (word == '0) begin
                     state_d = ST_CSUM;
                  end else begin
                     state_d = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (word_done) begin
                  wr_en_d    = 1'b1;
                  instr_d    = word;
                  csum_d     = csum ^ word;
                  word_cnt_d = word_cnt + CNT_W'(1);
                  if (word_cnt_d == len) begin
                     state_d = ST_CSUM;
                  end
               end
            end
            ST_CSUM: begin
               if (word_done) begin
                  if (word == csum) begin
                     state_d     = ST_DONE;
                     done_d      = 1'b1;
                     cpu_reset_d = 1'b1;
                  end else begin
                     state_d = ST_ERR;
                     err_d   = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
   end

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_i = 1'b0;
   logic [7:0]  byte_data_i = 8'h00;
   logic        byte_valid_i = 1'b0;
   logic        byte_ready_o;
   logic        wr_en_imem_o;
   logic [31:0] addr_imem_o;
   logic [31:0] wr_instr_imem_o;
   logic        cpu_reset_o;
   logic        load_done_o;
   logic        load_err_o;

   int n_cmp = 0;
   int n_err = 0;

   int          wr_count = 0;
   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
      .clk             (clk),
      .reset           (reset),
      .start_i         (start_i),
      .byte_data_i     (byte_data_i),
      .byte_valid_i    (byte_valid_i),
      .byte_ready_o    (byte_ready_o),
      .wr_en_imem_o    (wr_en_imem_o),
      .addr_imem_o     (addr_imem_o),
      .wr_instr_imem_o (wr_instr_imem_o),
      .cpu_reset_o     (cpu_reset_o),
      .load_done_o     (load_done_o),
      .load_err_o      (load_err_o)
   );

   always #5 clk = ~clk;

   // Record every cycle the write strobe is high
   always @(negedge clk) begin
      if (wr_en_imem_o) begin
         if (wr_count < 16) begin
            wr_addr[wr_count] = addr_imem_o;
            wr_data[wr_count] = wr_instr_imem_o;
         end
         wr_count = wr_count + 1;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      byte_valid_i = 1'b1;
      byte_data_i  = b;
      n = 0;
      while (!byte_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!byte_ready_o) begin
         $display("FAIL send_byte_timeout: byte_ready_o=%0b after %0d cycles, required 1", byte_ready_o, n);
         n_err++;
         n_cmp++;
         byte_valid_i = 1'b0;
      end else begin
         @(posedge clk);
         #1 byte_valid_i = 1'b0;
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_max);
      for (int i = 0; i < 4; i++) begin
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
         send_byte(w[8*i +: 8]);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
   endtask

   task automatic check_flags(input string name, input logic [4:0] exp);
      // ready, wr_en, cpu_reset, done, err
      @(negedge clk);
      if ({byte_ready_o, wr_en_imem_o, cpu_reset_o, load_done_o, load_err_o} !== exp) begin
         $display("FAIL %s: rdy/wr/cpu/done/err=%b, required %b", name,
                  {byte_ready_o, wr_en_imem_o, cpu_reset_o, load_done_o, load_err_o}, exp);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_reset();
      reset        = 1'b0;
      byte_valid_i = 1'b1;
      byte_data_i  = 8'hAA;
      wr_count     = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      if ({byte_ready_o, wr_en_imem_o, addr_imem_o, wr_instr_imem_o, cpu_reset_o, load_done_o, load_err_o}
          !== {1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL reset_values: rdy=%b wr=%b addr=%h data=%h cpu=%b done=%b err=%b, required 0 0 %h 0 0 0 0",
                  byte_ready_o, wr_en_imem_o, addr_imem_o, wr_instr_imem_o, cpu_reset_o, load_done_o, load_err_o, BASE);
         n_err++;
      end
      n_cmp++;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      byte_valid_i = 1'b0;
      if (wr_count !== 0 || byte_ready_o !== 1'b0) begin
         $display("FAIL reset_idle: writes=%0d rdy=%b, required 0 writes rdy 0", wr_count, byte_ready_o);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic run_image(input string name, input logic [31:0] csum_word, input int gap_max,
                            input logic [4:0] exp_end);
      pulse_start();
      wr_count = 0;
      check_flags({name, "_after_start"}, 5'b10000);
      send_word(32'd2, gap_max);
      send_word(32'h2008_0005, gap_max);
      if (gap_max == 0) begin
         @(negedge clk);
         if ({wr_en_imem_o, addr_imem_o, wr_instr_imem_o} !== {1'b1, BASE, 32'h2008_0005}) begin
            $display("FAIL %s_latency: wr=%b addr=%h data=%h, required 1 %h 20080005",
                     name, wr_en_imem_o, addr_imem_o, wr_instr_imem_o, BASE);
            n_err++;
         end
         n_cmp++;
      end
      send_word(32'h0000_0001, gap_max);
      send_word(csum_word, gap_max);
      check_flags({name, "_end"}, exp_end);
      if (wr_count !== 2 || wr_addr[0] !== BASE || wr_data[0] !== 32'h2008_0005 ||
          wr_addr[1] !== BASE + 32'd4 || wr_data[1] !== 32'h0000_0001) begin
         $display("FAIL %s_writes: n=%0d w0=%h@%h w1=%h@%h, required 2 20080005@%h 00000001@%h",
                  name, wr_count, wr_data[0], wr_addr[0], wr_data[1], wr_addr[1], BASE, BASE + 32'd4);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_good_image();
      run_image("good", 32'h2008_0004, 0, 5'b00110);
   endtask

   task automatic test_bad_csum();
      run_image("badcsum", 32'h2008_0005, 0, 5'b00001);
   endtask

   task automatic test_gaps();
      run_image("gaps", 32'h2008_0004, 5, 5'b00110);
   endtask

   task automatic test_length_limits();
      pulse_start();
      wr_count = 0;
      send_word(32'd257, 0);
      check_flags("too_long", 5'b00001);
      if (wr_count !== 0) begin
         $display("FAIL too_long_writes: n=%0d, required 0", wr_count);
         n_err++;
      end
      n_cmp++;
      pulse_start();
      wr_count = 0;
      send_word(32'd0, 0);
      check_flags("zero_len_hdr", 5'b10000);
      send_word(32'd0, 0);
      check_flags("zero_len_end", 5'b00110);
      if (wr_count !== 0) begin
         $display("FAIL zero_len_writes: n=%0d, required 0", wr_count);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_restart();
      pulse_start();
      send_word(32'd2, 0);
      send_word(32'h1122_3344, 0);
      send_byte(8'h55);
      send_byte(8'h66);
      // Restart with a byte on the bus: it must be dropped
      @(negedge clk);
      start_i      = 1'b1;
      byte_valid_i = 1'b1;
      byte_data_i  = 8'hEE;
      @(posedge clk);
      #1;
      start_i      = 1'b0;
      byte_valid_i = 1'b0;
      wr_count     = 0;
      @(negedge clk);
      if ({byte_ready_o, addr_imem_o, cpu_reset_o, load_done_o, load_err_o} !== {1'b1, BASE, 3'b000}) begin
         $display("FAIL restart_state: rdy=%b addr=%h cpu=%b done=%b err=%b, required 1 %h 0 0 0",
                  byte_ready_o, addr_imem_o, cpu_reset_o, load_done_o, load_err_o, BASE);
         n_err++;
      end
      n_cmp++;
      send_word(32'd1, 0);
      send_word(32'hDEAD_BEEF, 0);
      send_word(32'hDEAD_BEEF, 0);
      check_flags("restart_end", 5'b00110);
      if (wr_count !== 1 || wr_addr[0] !== BASE || wr_data[0] !== 32'hDEAD_BEEF) begin
         $display("FAIL restart_writes: n=%0d w0=%h@%h, required 1 deadbeef@%h",
                  wr_count, wr_data[0], wr_addr[0], BASE);
         n_err++;
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid_data();
      pulse_start();
      send_word(32'd2, 0);
      send_word(32'h0000_00AB, 0);
      send_byte(8'h01);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      if ({byte_ready_o, wr_en_imem_o, addr_imem_o, wr_instr_imem_o, cpu_reset_o, load_done_o, load_err_o}
          !== {1'b0, 1'b0, BASE, 32'h0, 1'b0, 1'b0, 1'b0}) begin
         $display("FAIL reset_mid: rdy=%b wr=%b addr=%h data=%h cpu=%b done=%b err=%b, required 0 0 %h 0 0 0 0",
                  byte_ready_o, wr_en_imem_o, addr_imem_o, wr_instr_imem_o, cpu_reset_o, load_done_o, load_err_o, BASE);
         n_err++;
      end
      n_cmp++;
   endtask

   initial begin
      test_reset();
      test_good_image();
      test_bad_csum();
      test_length_limits();
      test_gaps();
      test_restart();
      test_reset_mid_data();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface; the pipeline's fetch stage only reads instruction memory, and this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the instr_mem write port (address, data, write enable) and holds the CPU in reset until the image is loaded and its checksum matches.
- Sits in the top level next to instr_mem; it is the only driver of the imem write port.

Parameters:
- BASE_ADDR, 32'h0, byte address written with the first image word.
- MAX_WORDS, 256, largest accepted image length in words; a longer header is an error.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset
- start_i  in  1  one-cycle pulse: begin a new load, from any state
- byte_data_i  in  8  stream byte
- byte_valid_i  in  1  byte_data_i is valid
- byte_ready_o  out  1  loader accepts a byte this cycle
- wr_en_imem_o  out  1  one-cycle imem write strobe
- addr_imem_o  out  32  imem byte address (word aligned)
- wr_instr_imem_o  out  32  instruction word to write
- cpu_reset_o  out  1  active-low reset to the pipeline; low while loading or on error
- load_done_o  out  1  image loaded and checksum matched; sticky
- load_err_o  out  1  length or checksum error; sticky

Behaviour:
- Reset (reset==0 at a clk edge) puts the block in IDLE and clears all registers:
  - byte_ready_o=0, wr_en_imem_o=0, addr_imem_o=BASE_ADDR, wr_instr_imem_o=0.
  - cpu_reset_o=0, load_done_o=0, load_err_o=0.
  - Reset mid-load aborts the load; words already written stay in imem.
- A byte transfers only when byte_valid_i & byte_ready_o. byte_ready_o=1 in LEN, DATA and CSUM, and 0 in every other state.
- Byte assembly:
  - A 2-bit byte counter and a 32-bit shift register.
  - The k-th accepted byte (k=0..3) lands in bits [8k+7:8k].
  - The counter wraps 3->0 on the 4th byte; that byte completes the word.
- Image format, in stream order: length N (1 word), then N data words, then a checksum word equal to the XOR of all N data words.
- States:
  - IDLE: cpu_reset_o=0. start_i -> LEN.
  - LEN: on word completion latch N.
    - N>MAX_WORDS -> ERR.
    - N==0 -> CSUM.
    - otherwise -> DATA.
  - DATA, on each word completion:
    - Next cycle: wr_en_imem_o=1 for exactly one cycle, addr_imem_o=current address, wr_instr_imem_o=the word.
    - The running XOR is updated with the word, and the address increments by 4 after the write.
    - On the N-th word -> CSUM.
  - CSUM: on word completion compare the received word with the running XOR.
    - Equal -> DONE.
    - Not equal -> ERR.
  - DONE: cpu_reset_o=1, load_done_o=1.
  - ERR: load_err_o=1, cpu_reset_o=0.
- Latency: 4th byte of a data word accepted at edge t -> write strobe visible in the cycle after t. The memory write is single-cycle, so there is no backpressure from imem.
- Gaps (byte_valid_i low) can occur anywhere in the stream; the partial word is held with no timeout.
- start_i in any state:
  - Go to LEN and clear the byte counter, word counter, XOR and flags.
  - Reset the address to BASE_ADDR and drive cpu_reset_o=0 from the next cycle.
  - A byte presented in the same cycle as start_i is dropped.
- Counters:
  - The word counter is wide enough for MAX_WORDS.
  - Address arithmetic is 32-bit and wraps modulo 2^32; BASE_ADDR+4*MAX_WORDS never wraps, so a correct configuration never reaches the wrap.
- The block never writes imem outside DATA.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LEN, DATA, CSUM, DONE, ERR);
  - IMEM_ADDR_W=32 and INSTR_W=32;
  - the byte-lane constant BYTES_PER_WORD=4.
- One natural sub-module: byte_to_word_asm. It holds the shift register and the 2-bit counter, outputs word_o and word_done_o, and is cleared by start/reset.
- FSM, address counter, word counter and checksum stay in imem_loader.

Test Plan:
- Reset low 2 cycles with valid bytes present -> all outputs at reset values, no byte accepted, no write.
- start_i, then bytes 02 00 00 00 | 05 00 08 20 | 01 00 00 00 | 04 00 08 20 -> writes 0x20080005 @BASE_ADDR and 0x00000001 @BASE_ADDR+4, each a single-cycle strobe. Expected checksum is 0x20080005 ^ 0x00000001 = 0x20080004:
  - checksum bytes 04 00 08 20 -> load_done_o=1, cpu_reset_o=1, byte_ready_o=0;
  - repeat with checksum bytes 05 00 08 20 -> load_err_o=1, cpu_reset_o=0, done stays 0.
- Header N=MAX_WORDS+1 (01 01 00 00 for 257) -> ERR right after the 4th header byte, zero writes. Header N=0 followed by checksum 00000000 -> DONE, zero writes.
- Same image as above with byte_valid_i toggled randomly (gaps of 0-5 cycles) -> identical write sequence and DONE.
- start_i after 1 word and 2 bytes of the next -> state LEN, address back to BASE_ADDR, flags clear. A fresh 1-word image then writes @BASE_ADDR and reaches DONE. Reset asserted mid-DATA gives the same clean IDLE.
